// File: rtl/jmp_pc_unit_if.sv
// Bus between the decoder/ALU side and the jump / program-counter unit.
// The master side drives the decode and flag inputs; the slave side is the PC unit.
interface jmp_pc_unit_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned CNT_W  = 16
);
    logic              en;
    logic              instr_valid;
    logic              is_c;
    logic [2:0]        jbits;
    logic              zr;
    logic              ng;
    logic [ADDR_W-1:0] target;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic              flush;
    logic [CNT_W-1:0]  taken_cnt;
    logic              ras_err;

    modport master (
        output en, instr_valid, is_c, jbits, zr, ng, target, call, ret,
        input  pc, taken, flush, taken_cnt, ras_err
    );

    modport slave (
        input  en, instr_valid, is_c, jbits, zr, ng, target, call, ret,
        output pc, taken, flush, taken_cnt, ras_err
    );
endinterface

// File: rtl/jmp_pc_unit.sv
// Hack jump decision and program counter with stall support, a saturating
// taken-jump counter and a fetch-flush pulse.
// Optional return-address stack enabled by defining JMP_PC_RAS_EN.
module jmp_pc_unit #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    jmp_pc_unit_if.slave bus
);
    localparam logic [ADDR_W-1:0] PcReset = ADDR_W'(RESET_VEC);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              advance, cond, jump, taken_int;

    assign advance = bus.en & bus.instr_valid;
    // jL on negative, jE on zero, jG on strictly positive; zr=ng=1 taken literally
    assign cond    = (bus.jbits[2] & bus.ng) | (bus.jbits[1] & bus.zr) |
                     (bus.jbits[0] & ~bus.zr & ~bus.ng);
    assign jump    = advance & bus.is_c & cond;
    assign pc_inc  = pc_q + ADDR_W'(1);

`ifdef JMP_PC_RAS_EN
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
    logic [ADDR_W-1:0] stack_d [RAS_DEPTH];
    logic [PtrW:0]     sp_q, sp_d;
    logic              err_q, err_d;
    logic              ret_fire, pop_ok, pop_empty, push, ras_full;
    logic [PtrW-1:0]   top_idx;

    assign ret_fire  = advance & bus.ret;
    assign ras_full  = (sp_q == (PtrW+1)'(RAS_DEPTH));
    assign pop_ok    = ret_fire & (sp_q != '0);
    assign pop_empty = ret_fire & (sp_q == '0);
    // A return on the same cycle suppresses the jump (and therefore any call)
    assign taken_int = jump & ~bus.ret;
    assign push      = taken_int & bus.call;
    assign top_idx   = sp_q[PtrW-1:0] - PtrW'(1);

    // Stack next state: pop, underflow, push or dropped push on overflow
    always_comb begin
        stack_d = stack_q;
        sp_d    = sp_q;
        err_d   = err_q;
        if (pop_ok) begin
            sp_d = sp_q - (PtrW+1)'(1);
        end else if (pop_empty) begin
            err_d = 1'b1;
        end else if (push) begin
            if (ras_full) begin
                err_d = 1'b1;
            end else begin
                stack_d[sp_q[PtrW-1:0]] = pc_inc;
                sp_d                    = sp_q + (PtrW+1)'(1);
            end
        end
    end

    // PC and flush next state: return beats jump beats sequential advance
    always_comb begin
        pc_d = pc_q;
        if (pop_ok) begin
            pc_d = stack_q[top_idx];
        end else if (taken_int) begin
            pc_d = bus.target;
        end else if (advance) begin
            pc_d = pc_inc;
        end
        flush_d = taken_int | pop_ok;
    end

    // Stack state registers with synchronous reset to empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stack_q <= '{default: '0};
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            stack_q <= stack_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    assign bus.ras_err = err_q;
`else
    logic unused_ras;

    assign unused_ras = bus.call ^ bus.ret;
    assign taken_int  = jump;

    // PC and flush next state: jump or sequential advance, hold on stall/bubble
    always_comb begin
        pc_d = pc_q;
        if (taken_int) begin
            pc_d = bus.target;
        end else if (advance) begin
            pc_d = pc_inc;
        end
        flush_d = taken_int;
    end

    assign bus.ras_err = 1'b0;
`endif

    // Taken-jump counter saturates at all-ones; returns are not counted
    always_comb begin
        cnt_d = cnt_q;
        if (taken_int && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Core state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= PcReset;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.taken     = taken_int;
    assign bus.flush     = flush_q;
    assign bus.taken_cnt = cnt_q;
endmodule

// File: tb/tb_jmp_pc_unit.sv
// Self-checking bench for jmp_pc_unit: directed scenarios plus random traffic
// checked against a queue-based behavioural model.
module tb_jmp_pc_unit;
    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned RAS_DEPTH = 4;
    localparam int unsigned RESET_VEC = 0;
    localparam int          PC_MOD    = 1 << ADDR_W;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;
`ifdef JMP_PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_pc    = RESET_VEC;
    bit m_flush = 1'b0;
    int m_cnt   = 0;
    bit m_err   = 1'b0;
    int m_stack[$];
    bit exp_taken;
    bit obs_taken;

    jmp_pc_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    jmp_pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_VEC(RESET_VEC),
        .CNT_W    (CNT_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic bit jump_cond(input bit [2:0] jb, input bit z, input bit n);
        bit negative = n;
        bit zero     = z;
        bit positive = !z && !n;
        return (jb[2] && negative) || (jb[1] && zero) || (jb[0] && positive);
    endfunction

    // One clock: apply inputs, sample taken mid-cycle, advance the model at the edge
    task automatic cycle(input bit en_v, input bit iv, input bit isc, input bit [2:0] jb,
                         input bit z, input bit n, input int tgt, input bit cl, input bit rt);
        bus.en          = en_v;
        bus.instr_valid = iv;
        bus.is_c        = isc;
        bus.jbits       = jb;
        bus.zr          = z;
        bus.ng          = n;
        bus.target      = tgt[ADDR_W-1:0];
        bus.call        = cl;
        bus.ret         = rt;
        exp_taken = en_v && iv && isc && jump_cond(jb, z, n) && !(RAS_ON && rt);
        @(negedge clk);
        obs_taken = bus.taken;
        @(posedge clk);
        m_flush = 1'b0;
        if (!rst_n) begin
            m_pc  = RESET_VEC;
            m_cnt = 0;
            m_err = 1'b0;
            m_stack.delete();
        end else if (en_v && iv) begin
            if (RAS_ON && rt) begin
                if (m_stack.size() > 0) begin
                    m_pc    = m_stack.pop_back();
                    m_flush = 1'b1;
                end else begin
                    m_pc  = (m_pc + 1) % PC_MOD;
                    m_err = 1'b1;
                end
            end else if (exp_taken) begin
                if (RAS_ON && cl) begin
                    if (m_stack.size() < RAS_DEPTH) m_stack.push_back((m_pc + 1) % PC_MOD);
                    else m_err = 1'b1;
                end
                m_pc    = tgt % PC_MOD;
                m_flush = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
        #1;
    endtask

    task automatic nop_cycle();
        cycle(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nop_cycle();
        nop_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        nop_cycle();
        nop_cycle();
        checks++;
        if (bus.pc !== ADDR_W'(RESET_VEC)) begin
            errors++;
            $display("FAIL reset_pc: got %0h expected %0h", bus.pc, RESET_VEC);
        end
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: got %0b expected 0", bus.flush);
        end
        checks++;
        if (bus.taken_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", bus.taken_cnt);
        end
        checks++;
        if (bus.ras_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %0b expected 0", bus.ras_err);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nop_cycle();
            checks++;
            if (bus.pc !== ADDR_W'(i + 1)) begin
                errors++;
                $display("FAIL release_pc%0d: got %0h expected %0h", i, bus.pc, i + 1);
            end
        end
    endtask

    task automatic test_jump_matrix();
        for (int jb = 0; jb < 8; jb++) begin
            for (int f = 0; f < 4; f++) begin
                bit [1:0] fl = f[1:0];
                cycle(1'b1, 1'b1, 1'b1, jb[2:0], fl[1], fl[0], 'h1234, 1'b0, 1'b0);
                checks++;
                if (obs_taken !== exp_taken) begin
                    errors++;
                    $display("FAIL matrix_taken j=%0d zn=%0d: got %0b expected %0b",
                             jb, f, obs_taken, exp_taken);
                end
                checks++;
                if (bus.pc !== m_pc[ADDR_W-1:0]) begin
                    errors++;
                    $display("FAIL matrix_pc j=%0d zn=%0d: got %0h expected %0h",
                             jb, f, bus.pc, m_pc);
                end
                checks++;
                if (bus.flush !== m_flush) begin
                    errors++;
                    $display("FAIL matrix_flush j=%0d zn=%0d: got %0b expected %0b",
                             jb, f, bus.flush, m_flush);
                end
                checks++;
                if (bus.taken_cnt !== m_cnt[CNT_W-1:0]) begin
                    errors++;
                    $display("FAIL matrix_cnt j=%0d zn=%0d: got %0d expected %0d",
                             jb, f, bus.taken_cnt, m_cnt);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [ADDR_W-1:0] pc_before;
        logic [CNT_W-1:0]  cnt_before;
        // Make flush high first so the stall must clear it
        cycle(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 'h0400, 1'b0, 1'b0);
        pc_before  = bus.pc;
        cnt_before = bus.taken_cnt;
        cycle(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 'h0555, 1'b0, 1'b0);
        checks++;
        if (obs_taken !== 1'b0) begin
            errors++;
            $display("FAIL stall_taken: got %0b expected 0", obs_taken);
        end
        checks++;
        if (bus.pc !== pc_before) begin
            errors++;
            $display("FAIL stall_pc: got %0h expected %0h", bus.pc, pc_before);
        end
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush: got %0b expected 0", bus.flush);
        end
        checks++;
        if (bus.taken_cnt !== cnt_before) begin
            errors++;
            $display("FAIL stall_cnt: got %0d expected %0d", bus.taken_cnt, cnt_before);
        end
        cycle(1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 'h0555, 1'b0, 1'b0);
        checks++;
        if (obs_taken !== 1'b0) begin
            errors++;
            $display("FAIL bubble_taken: got %0b expected 0", obs_taken);
        end
        checks++;
        if (bus.pc !== pc_before) begin
            errors++;
            $display("FAIL bubble_pc: got %0h expected %0h", bus.pc, pc_before);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 'h7FFF, 1'b0, 1'b0);
        checks++;
        if (bus.pc !== 15'h7FFF) begin
            errors++;
            $display("FAIL wrap_setup: got %0h expected 7fff", bus.pc);
        end
        nop_cycle();
        checks++;
        if (bus.pc !== 15'h0000) begin
            errors++;
            $display("FAIL wrap_pc: got %0h expected 0", bus.pc);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, int'($urandom_range(0, PC_MOD - 1)),
                  1'b0, 1'b0);
            checks++;
            if (bus.taken_cnt !== m_cnt[CNT_W-1:0]) begin
                errors++;
                $display("FAIL sat_cnt%0d: got %0d expected %0d", i, bus.taken_cnt, m_cnt);
            end
        end
        checks++;
        if (bus.taken_cnt !== CNT_W'(CNT_MAX)) begin
            errors++;
            $display("FAIL sat_final: got %0d expected %0d", bus.taken_cnt, CNT_MAX);
        end
    endtask

    task automatic test_ras();
        // {is_c, jbits, target, call, ret} with en=instr_valid=1
        bit        t_isc [16] = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
        bit [2:0]  t_jb  [16] = '{7, 7, 0, 7, 7, 7, 7, 7, 0, 0, 0, 0, 0, 7, 7, 0};
        int        t_tgt [16] = '{'h10, 'h100, 0, 'h200, 'h210, 'h220, 'h230, 'h240,
                                  0, 0, 0, 0, 0, 'h300, 'h400, 0};
        bit        t_cl  [16] = '{0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
        bit        t_rt  [16] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1, 1};
        logic [ADDR_W-1:0] pc_log [16];
        logic              fl_log [16];
        logic              er_log [16];
        logic              tk_log [16];
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, t_isc[i], t_jb[i], 1'b0, 1'b0, t_tgt[i], t_cl[i], t_rt[i]);
            pc_log[i] = bus.pc;
            fl_log[i] = bus.flush;
            er_log[i] = bus.ras_err;
            tk_log[i] = obs_taken;
            checks++;
            if (obs_taken !== exp_taken) begin
                errors++;
                $display("FAIL ras_taken%0d: got %0b expected %0b", i, obs_taken, exp_taken);
            end
            checks++;
            if (bus.pc !== m_pc[ADDR_W-1:0]) begin
                errors++;
                $display("FAIL ras_pc%0d: got %0h expected %0h", i, bus.pc, m_pc);
            end
            checks++;
            if (bus.flush !== m_flush) begin
                errors++;
                $display("FAIL ras_flush%0d: got %0b expected %0b", i, bus.flush, m_flush);
            end
            checks++;
            if (bus.ras_err !== m_err) begin
                errors++;
                $display("FAIL ras_err%0d: got %0b expected %0b", i, bus.ras_err, m_err);
            end
        end
`ifdef JMP_PC_RAS_EN
        checks++;
        if (pc_log[2] !== 15'h11 || fl_log[2] !== 1'b1) begin
            errors++;
            $display("FAIL ras_return: got pc=%0h flush=%0b expected pc=11 flush=1",
                     pc_log[2], fl_log[2]);
        end
        checks++;
        if (er_log[6] !== 1'b0 || er_log[7] !== 1'b1) begin
            errors++;
            $display("FAIL ras_overflow: got %0b%0b expected 01", er_log[6], er_log[7]);
        end
        checks++;
        if (pc_log[8] !== 15'h221 || pc_log[11] !== 15'h12 || fl_log[11] !== 1'b1) begin
            errors++;
            $display("FAIL ras_nested: got %0h/%0h/%0b expected 221/12/1",
                     pc_log[8], pc_log[11], fl_log[11]);
        end
        checks++;
        if (pc_log[12] !== 15'h13 || fl_log[12] !== 1'b0 || er_log[12] !== 1'b1) begin
            errors++;
            $display("FAIL ras_underflow: got %0h/%0b/%0b expected 13/0/1",
                     pc_log[12], fl_log[12], er_log[12]);
        end
        checks++;
        if (pc_log[14] !== 15'h14 || fl_log[14] !== 1'b1 || tk_log[14] !== 1'b0) begin
            errors++;
            $display("FAIL ras_collide: got %0h/%0b/%0b expected 14/1/0",
                     pc_log[14], fl_log[14], tk_log[14]);
        end
        checks++;
        if (pc_log[15] !== 15'h15 || fl_log[15] !== 1'b0) begin
            errors++;
            $display("FAIL ras_collide_pop_only: got %0h/%0b expected 15/0",
                     pc_log[15], fl_log[15]);
        end
`else
        checks++;
        if (pc_log[2] !== 15'h101 || fl_log[2] !== 1'b0) begin
            errors++;
            $display("FAIL noras_ret: got pc=%0h flush=%0b expected pc=101 flush=0",
                     pc_log[2], fl_log[2]);
        end
        checks++;
        if (pc_log[14] !== 15'h400 || tk_log[14] !== 1'b1) begin
            errors++;
            $display("FAIL noras_collide: got %0h/%0b expected 400/1", pc_log[14], tk_log[14]);
        end
        checks++;
        if (er_log[15] !== 1'b0 || pc_log[15] !== 15'h401) begin
            errors++;
            $display("FAIL noras_err: got %0b/%0h expected 0/401", er_log[15], pc_log[15]);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 'h050, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 'h060, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 'h070, 1'b1, 1'b0);
        rst_n = 1'b0;
        cycle(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 'h070, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 'h070, 1'b1, 1'b0);
        rst_n = 1'b1;
        checks++;
        if (bus.pc !== ADDR_W'(RESET_VEC) || bus.flush !== 1'b0 || bus.ras_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got pc=%0h flush=%0b err=%0b expected %0h/0/0",
                     bus.pc, bus.flush, bus.ras_err, RESET_VEC);
        end
        cycle(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        checks++;
        if (bus.pc !== ADDR_W'(RESET_VEC + 1) || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ret_pc: got %0h/%0b expected %0h/0",
                     bus.pc, bus.flush, RESET_VEC + 1);
        end
        checks++;
        if (bus.ras_err !== m_err) begin
            errors++;
            $display("FAIL midreset_ret_err: got %0b expected %0b", bus.ras_err, m_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bit [1:0] fl = 2'($urandom);
            cycle(($urandom % 8) != 0, ($urandom % 6) != 0, 1'($urandom), 3'($urandom),
                  fl[1], fl[0], int'($urandom_range(0, PC_MOD - 1)),
                  ($urandom % 3) == 0, ($urandom % 6) == 0);
            checks++;
            if (obs_taken !== exp_taken) begin
                errors++;
                $display("FAIL rnd_taken%0d: got %0b expected %0b", i, obs_taken, exp_taken);
            end
            checks++;
            if (bus.pc !== m_pc[ADDR_W-1:0]) begin
                errors++;
                $display("FAIL rnd_pc%0d: got %0h expected %0h", i, bus.pc, m_pc);
            end
            checks++;
            if (bus.flush !== m_flush) begin
                errors++;
                $display("FAIL rnd_flush%0d: got %0b expected %0b", i, bus.flush, m_flush);
            end
            checks++;
            if (bus.taken_cnt !== m_cnt[CNT_W-1:0]) begin
                errors++;
                $display("FAIL rnd_cnt%0d: got %0d expected %0d", i, bus.taken_cnt, m_cnt);
            end
            checks++;
            if (bus.ras_err !== m_err) begin
                errors++;
                $display("FAIL rnd_err%0d: got %0b expected %0b", i, bus.ras_err, m_err);
            end
        end
    endtask

    initial begin
        bus.en          = 1'b0;
        bus.instr_valid = 1'b0;
        bus.is_c        = 1'b0;
        bus.jbits       = 3'b000;
        bus.zr          = 1'b0;
        bus.ng          = 1'b0;
        bus.target      = '0;
        bus.call        = 1'b0;
        bus.ret         = 1'b0;
        test_reset();
        test_jump_matrix();
        test_stall();
        test_wrap();
        test_saturate();
        test_ras();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
